// File: rtl/bdr_port_scheduler.sv
// Write-port scheduler for the BDR register bank: two buffered writeback requesters
// arbitrated round-robin, a sequenced bank clear, and read-after-write hazard flags.
module bdr_port_scheduler #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_dest,
  output logic [DATA_W-1:0] write_data
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

  state_t            state, state_next;
  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_dest_q, b_dest_q;
  logic [DATA_W-1:0] a_data_q, b_data_q;
  logic              rr_b;
  logic [ADDR_W-1:0] clr_cnt;
  logic              accept_a, accept_b, grant_a, grant_b, clr_last;

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign a_ready  = reset && !a_full && (state == ST_RUN);
  assign b_ready  = reset && !b_full && (state == ST_RUN);
  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;
  assign clr_last = (clr_cnt == LAST_REG);
  assign clr_busy = (state != ST_RUN);

  assign grant_a = (state != ST_CLEAR) && a_full && (!b_full || !rr_b);
  assign grant_b = (state != ST_CLEAR) && b_full && (!a_full ||  rr_b);

  // Any entry still buffered or arriving with the clear request must land before the clear.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:
        if (clr_req)
          state_next = (a_full || b_full || accept_a || accept_b) ? ST_DRAIN : ST_CLEAR;
      ST_DRAIN:
        if (!a_full && !b_full) state_next = ST_CLEAR;
      ST_CLEAR:
        if (clr_last) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    hazard1 = (a_full && a_dest_q == rd_addr1) || (b_full && b_dest_q == rd_addr1)
           || (reg_write && write_dest == rd_addr1) || (state != ST_RUN);
    hazard2 = (a_full && a_dest_q == rd_addr2) || (b_full && b_dest_q == rd_addr2)
           || (reg_write && write_dest == rd_addr2) || (state != ST_RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      clr_cnt <= '0;
      rr_b    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);
      if (grant_a)      rr_b <= 1'b1;
      else if (grant_b) rr_b <= 1'b0;
    end
  end

  // A buffer is never granted and refilled at the same edge, since ready is low while full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_full   <= 1'b0;
      b_full   <= 1'b0;
      a_dest_q <= '0;
      b_dest_q <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (grant_a) a_full <= 1'b0;
      else if (accept_a) begin
        a_full   <= 1'b1;
        a_dest_q <= a_dest;
        a_data_q <= a_data;
      end
      if (grant_b) b_full <= 1'b0;
      else if (accept_b) begin
        b_full   <= 1'b1;
        b_dest_q <= b_dest;
        b_data_q <= b_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_write  <= 1'b0;
      write_dest <= '0;
      write_data <= '0;
    end else if (state == ST_CLEAR) begin
      reg_write  <= 1'b1;
      write_dest <= clr_cnt;
      write_data <= '0;
    end else if (grant_a) begin
      reg_write  <= 1'b1;
      write_dest <= a_dest_q;
      write_data <= a_data_q;
    end else if (grant_b) begin
      reg_write  <= 1'b1;
      write_dest <= b_dest_q;
      write_data <= b_data_q;
    end else begin
      reg_write  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bdr_port_scheduler.sv
// Self-checking bench for bdr_port_scheduler: a table of per-cycle vectors plus
// hand-written sequences for arbitration order, hazards, bank clear and reset abort.
module tb_bdr_port_scheduler;

  logic       clock, reset;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [2:0] a_dest, b_dest, rd_addr1, rd_addr2, write_dest;
  logic [7:0] a_data, b_data, write_data;
  logic       clr_req, clr_busy, hazard1, hazard2, reg_write;

  int n_compared = 0;
  int n_mismatch = 0;
  int busy_cycles;

  typedef struct {
    logic       a_valid;
    logic [2:0] a_dest;
    logic [7:0] a_data;
    logic       b_valid;
    logic [2:0] b_dest;
    logic [7:0] b_data;
    logic [2:0] rd1;
    logic [2:0] rd2;
    logic       exp_a_ready;
    logic       exp_b_ready;
    logic       exp_busy;
    logic       exp_h1;
    logic       exp_h2;
    logic       exp_we;
    logic [2:0] exp_dest;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  bdr_port_scheduler #(.DATA_W(8), .ADDR_W(3), .NREGS(8)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2),
    .reg_write(reg_write), .write_dest(write_dest), .write_data(write_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ar, input logic br, input logic busy,
                          input logic h1, input logic h2, input logic we,
                          input logic [2:0] d, input logic [7:0] dat);
    checkOutput({tag, ".a_ready"},    8'(a_ready),    8'(ar));
    checkOutput({tag, ".b_ready"},    8'(b_ready),    8'(br));
    checkOutput({tag, ".clr_busy"},   8'(clr_busy),   8'(busy));
    checkOutput({tag, ".hazard1"},    8'(hazard1),    8'(h1));
    checkOutput({tag, ".hazard2"},    8'(hazard2),    8'(h2));
    checkOutput({tag, ".reg_write"},  8'(reg_write),  8'(we));
    checkOutput({tag, ".write_dest"}, 8'(write_dest), 8'(d));
    checkOutput({tag, ".write_data"}, write_data,     dat);
  endtask

  task automatic applyStimulus(input vec_t v);
    a_valid  = v.a_valid;
    a_dest   = v.a_dest;
    a_data   = v.a_data;
    b_valid  = v.b_valid;
    b_dest   = v.b_dest;
    b_data   = v.b_data;
    rd_addr1 = v.rd1;
    rd_addr2 = v.rd2;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_dest = 3'd0; a_data = 8'h00;
    b_valid = 1'b0; b_dest = 3'd0; b_data = 8'h00;
    clr_req = 1'b0; rd_addr1 = 3'd0; rd_addr2 = 3'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd5, 8'h08, 1'b0, 3'd0, 8'h00, 3'd5, 3'd0,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd5, 3'd0,
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h08};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd5, 3'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h08};
    vecs[3]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd1, 8'h22, 3'd1, 3'd2,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'h08};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h22};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd1, 3'd0,
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h11};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd1, 3'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h11};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h5A, 3'd0, 3'd6,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'h11};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h77, 3'd0, 3'd6,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 8'h5A};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h77, 3'd6, 3'd7,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 8'h5A};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd7, 3'd7,
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 8'h77};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0, 3'd7,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 8'h77};

    idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #2;
    checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge clock);
    reset = 1'b1;

    // Table: each vector is held across one edge, outputs checked just after it.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].exp_a_ready, vecs[i].exp_b_ready,
               vecs[i].exp_busy, vecs[i].exp_h1, vecs[i].exp_h2, vecs[i].exp_we,
               vecs[i].exp_dest, vecs[i].exp_data);
    end

    // Simultaneous requests to the same register with the pointer at A after reset.
    do_reset();
    a_valid = 1'b1; a_dest = 3'd1; a_data = 8'h11;
    b_valid = 1'b1; b_dest = 3'd1; b_data = 8'h22;
    tick();
    idle();
    checkOutput("rr.accept_a_ready", 8'(a_ready), 8'h0);
    tick();
    checkOutput("rr.first_we",   8'(reg_write), 8'h1);
    checkOutput("rr.first_data", write_data,    8'h11);
    tick();
    checkOutput("rr.second_we",   8'(reg_write), 8'h1);
    checkOutput("rr.second_data", write_data,    8'h22);
    tick();
    checkOutput("rr.final_we",   8'(reg_write), 8'h0);
    checkOutput("rr.final_data", write_data,    8'h22);

    // Both ports streaming: grants alternate A, B and the write port never idles.
    do_reset();
    a_valid = 1'b1; a_dest = 3'd2; a_data = 8'hA2;
    b_valid = 1'b1; b_dest = 3'd3; b_data = 8'hB3;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c >= 2) begin
        checkOutput($sformatf("b2b.c%0d.we", c),   8'(reg_write),  8'h1);
        checkOutput($sformatf("b2b.c%0d.dest", c), 8'(write_dest), (c % 2 == 0) ? 8'd2 : 8'd3);
      end
    end
    idle();
    repeat (4) tick();

    // Hazard tracks a buffered B entry until its write cycle ends.
    do_reset();
    b_valid = 1'b1; b_dest = 3'd3; b_data = 8'h33;
    rd_addr1 = 3'd3; rd_addr2 = 3'd4;
    tick();
    b_valid = 1'b0;
    checkOutput("haz.buf_h1", 8'(hazard1), 8'h1);
    checkOutput("haz.buf_h2", 8'(hazard2), 8'h0);
    tick();
    checkOutput("haz.we_h1", 8'(hazard1),   8'h1);
    checkOutput("haz.we",    8'(reg_write), 8'h1);
    checkOutput("haz.we_h2", 8'(hazard2),   8'h0);
    tick();
    checkOutput("haz.done_h1", 8'(hazard1), 8'h0);

    // Clear with A buffered: A lands first, then R0..R7 are zeroed.
    do_reset();
    busy_cycles = 0;
    a_valid = 1'b1; a_dest = 3'd5; a_data = 8'hAA;
    tick();
    idle();
    clr_req = 1'b1; rd_addr2 = 3'd1;
    tick();
    if (clr_busy) busy_cycles++;
    checkAll("clr.drain", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 8'hAA);
    tick();
    if (clr_busy) busy_cycles++;
    checkOutput("clr.gap_we",   8'(reg_write), 8'h0);
    checkOutput("clr.gap_busy", 8'(clr_busy),  8'h1);
    for (int k = 0; k < 8; k++) begin
      clr_req = (k < 5);
      tick();
      if (clr_busy) busy_cycles++;
      checkOutput($sformatf("clr.w%0d.we", k),   8'(reg_write),  8'h1);
      checkOutput($sformatf("clr.w%0d.dest", k), 8'(write_dest), 8'(k));
      checkOutput($sformatf("clr.w%0d.data", k), write_data,     8'h00);
      checkOutput($sformatf("clr.w%0d.busy", k), 8'(clr_busy),   (k < 7) ? 8'h1 : 8'h0);
    end
    checkOutput("clr.end_a_ready", 8'(a_ready), 8'h1);
    tick();
    if (clr_busy) busy_cycles++;
    checkOutput("clr.after_we", 8'(reg_write), 8'h0);
    checkOutput("clr.busy_cycles", 8'(busy_cycles), 8'd9);

    // Reset during the third clear write aborts it for good.
    do_reset();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checkOutput("abort.direct_busy", 8'(clr_busy),  8'h1);
    checkOutput("abort.direct_we",   8'(reg_write), 8'h0);
    repeat (3) tick();
    checkOutput("abort.pre_dest", 8'(write_dest), 8'd2);
    #2;
    reset = 1'b0;
    #1;
    checkAll("abort.in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("abort.a_ready", 8'(a_ready),  8'h1);
    checkOutput("abort.b_ready", 8'(b_ready),  8'h1);
    tick();
    checkOutput("abort.no_resume_we",   8'(reg_write), 8'h0);
    checkOutput("abort.no_resume_busy", 8'(clr_busy),  8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
